// File: rtl/bfloat_mult_pkg.sv
// Shared types and constants for the shared bfloat mantissa multiplier and its arbiter.
package bfloat_mult_pkg;

    localparam int MANT_W          = 9;
    localparam int PROD_W          = 16;
    localparam int MUL_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/bfloat_mantissa_mult.sv
// Pipelined 9x9 mantissa multiplier; the product appears LAT clock edges after the operands.
// Stage registers carry no reset: the arbiter's valid pipe qualifies the output.
module bfloat_mantissa_mult
    import bfloat_mult_pkg::*;
#(
    parameter int LAT = MUL_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    output logic [PROD_W-1:0] out
);

    logic [PROD_W-1:0] stage [LAT];

    always_ff @(posedge clk) begin
        stage[0] <= PROD_W'(a) * PROD_W'(b);
        for (int unsigned i = 1; i < LAT; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign out = stage[LAT-1];

endmodule

// File: rtl/bfloat_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req starting at ptr (wrapping) and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            j = int'(ptr) + off;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (en && !found && req[j]) begin
                grant[j] = 1'b1;
                idx      = ID_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bfloat_mult_arbiter.sv
// Shares one pipelined mantissa multiplier among NUM_REQ requesters with round-robin issue,
// ID-tagged response routing and a drain handshake. Optional perf counters: BFLOAT_ARB_PERF_EN.
module bfloat_mult_arbiter
    import bfloat_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MANT_W-1:0] req_a,
    input  logic [NUM_REQ*MANT_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [PROD_W-1:0]         rsp_data,
    input  logic                      drain_req,
    output logic                      drained
`ifdef BFLOAT_ARB_PERF_EN
   ,output logic [31:0]               perf_issue_cnt,
    output logic [31:0]               perf_conflict_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant;
    logic                arb_en;
    logic                issue;
    logic                rsp_any;
    logic [MUL_LAT-1:0]  vpipe;
    logic [ID_W-1:0]     idpipe [MUL_LAT];
    logic [CNT_W-1:0]    inflight, inflight_nxt;
    logic [MANT_W-1:0]   mul_a, mul_b;
    logic [PROD_W-1:0]   mul_out;

    assign arb_en = (state == RUN);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req_ready = grant;
    assign issue     = |grant;
    assign mul_a     = issue ? req_a[grant_idx*MANT_W +: MANT_W] : '0;
    assign mul_b     = issue ? req_b[grant_idx*MANT_W +: MANT_W] : '0;

    bfloat_mantissa_mult #(.LAT(MUL_LAT)) u_mult (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .out (mul_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) idpipe[i] <= '0;
        end else begin
            vpipe[0]  <= issue;
            idpipe[0] <= grant_idx;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                vpipe[i]  <= vpipe[i-1];
                idpipe[i] <= idpipe[i-1];
            end
        end
    end

    assign rsp_any  = vpipe[MUL_LAT-1];
    assign rsp_data = mul_out;

    always_comb begin
        rsp_valid = '0;
        if (rsp_any) rsp_valid[idpipe[MUL_LAT-1]] = 1'b1;
    end

    assign inflight_nxt = inflight + CNT_W'(issue) - CNT_W'(rsp_any);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            rr_ptr   <= '0;
            inflight <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            if (issue) begin
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // DRAIN looks at the post-update count so HALT follows the last response by one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN:   if (inflight_nxt == '0) state_nxt = HALT;
            HALT:    if (!drain_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign drained = (state == HALT);

`ifdef BFLOAT_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (state == RUN && $countones(req_valid) > 1) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bfloat_mult_arbiter.sv
// Directed bench for bfloat_mult_arbiter (NUM_REQ=4, MUL_LAT=4); perf counters checked with BFLOAT_ARB_PERF_EN.
module tb_bfloat_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [35:0] req_a, req_b;
    logic [3:0]  req_ready, rsp_valid;
    logic [15:0] rsp_data;
    logic        drain_req, drained;
`ifdef BFLOAT_ARB_PERF_EN
    logic [31:0] perf_issue_cnt, perf_conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bfloat_mult_arbiter #(.NUM_REQ(4), .MUL_LAT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .drain_req (drain_req),
        .drained   (drained)
`ifdef BFLOAT_ARB_PERF_EN
       ,.perf_issue_cnt    (perf_issue_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [8:0] a, input logic [8:0] b);
        req_a[i*9 +: 9] = a;
        req_b[i*9 +: 9] = b;
    endtask

    // One cycle: drive inputs just after negedge, then check combinational outputs 1 time unit later.
    task automatic step(input string tag, input logic [3:0] v, input logic d, input logic r,
                        input bit chk_en, input logic [3:0] er, input logic [3:0] ev, input logic ed);
        @(negedge clk);
        req_valid = v;
        drain_req = d;
        rst       = r;
        #1;
        if (chk_en) begin
            chk({tag, ".ready"},   32'(req_ready), 32'(er));
            chk({tag, ".rsp"},     32'(rsp_valid), 32'(ev));
            chk({tag, ".drained"}, 32'(drained),   32'(ed));
        end
    endtask

    logic [3:0]  t3_v  [8];
    logic [3:0]  t3_r  [8];
    logic [3:0]  t3_s  [8];
    logic [15:0] prod  [4];
    logic [3:0]  dr_v  [14];
    logic        dr_d  [14];
    logic [3:0]  dr_r  [14];
    logic [3:0]  dr_s  [14];
    logic        dr_h  [14];

    initial begin
        rst = 1'b1; req_valid = '0; drain_req = 1'b0; req_a = '0; req_b = '0;
        step("rst0", 4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step("rst1", 4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step("reset", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        chk("reset.inflight", 32'(dut.inflight), 32'd0);
        chk("reset.rr_ptr",   32'(dut.rr_ptr),   32'd0);

        // Single request from requester 2: 3*5 = 15 after 4 cycles.
        set_op(2, 9'd3, 9'd5);
        step("single.g", 4'b0100, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0);
        for (int k = 1; k < 4; k++) step("single.w", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step("single.r", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0);
        chk("single.data", 32'(rsp_data), 32'd15);

        // rr_ptr is 3; lone grant to 1 moves it to 2, then 1 and 3 contend: 3, 1, 3.
        t3_v = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        t3_r = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        t3_s = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
        for (int k = 0; k < 8; k++) step("rr13", t3_v[k], 1'b0, 1'b0, 1'b1, t3_r[k], t3_s[k], 1'b0);

        // Full throughput from reset: grants 0,1,2,3,0,... and matching responses 4 cycles later.
        step("rst2", 4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        set_op(0, 9'h080, 9'h080); prod[0] = 16'h4000;
        set_op(1, 9'd3,   9'd7);   prod[1] = 16'd21;
        set_op(2, 9'h0FF, 9'h0FF); prod[2] = 16'hFE01;
        set_op(3, 9'h000, 9'h0AB); prod[3] = 16'h0000;
        for (int k = 0; k < 12; k++) begin
            step("full", (k < 8) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, 1'b1,
                 (k < 8) ? 4'(1 << (k % 4)) : 4'b0000,
                 (k >= 4) ? 4'(1 << ((k - 4) % 4)) : 4'b0000, 1'b0);
            if (k >= 4) chk("full.data", 32'(rsp_data), 32'(prod[(k - 4) % 4]));
        end

        // Drain with three ops in flight; drain_req rises together with the third grant.
        set_op(0, 9'd2, 9'd2);
        dr_v = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        dr_d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        dr_r = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        dr_s = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        dr_h = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 14; k++) step("drain", dr_v[k], dr_d[k], 1'b0, 1'b1, dr_r[k], dr_s[k], dr_h[k]);
        chk("drain.data", 32'(rsp_data), 32'd4);

        // rr_ptr is 1: four grants 1,2,3,0, then reset with all four in flight.
        step("inflt", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0);
        step("inflt", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0);
        step("inflt", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b0);
        step("inflt", 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
        step("rst3", 4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step("post_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        chk("post_rst.inflight", 32'(dut.inflight), 32'd0);
        chk("post_rst.rr_ptr",   32'(dut.rr_ptr),   32'd0);
        for (int k = 0; k < 3; k++) step("post_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step("post_rst.g", 4'b1010, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) step("post_rst.w", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        step("post_rst.r", 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0);
        chk("post_rst.data", 32'(rsp_data), 32'd21);

`ifdef BFLOAT_ARB_PERF_EN
        step("rst4", 4'b0000, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
        step("perf0", 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("perf.issue0",    perf_issue_cnt,    32'd0);
        chk("perf.conflict0", perf_conflict_cnt, 32'd0);
        for (int k = 0; k < 5; k++) step("perf", 4'b1111, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step("perf", 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0);
        step("perf", 4'b0100, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step("perf", 4'b1000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        step("perf_end", 4'b0000, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("perf.issue",    perf_issue_cnt,    32'd8);
        chk("perf.conflict", perf_conflict_cnt, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
